// File: rtl/weight_mem_pkg.sv
// Shared definitions for the weight-memory sequencer.
package weight_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Four 324-bit write words make one 1296-bit read row.
   localparam int WORDS_PER_ROW = 4;

   // A read row address must cover exactly a quarter of the write space.
   function automatic bit rd_depth_ok(input int wr_depth, input int rd_depth);
      return rd_depth == wr_depth - 2;
   endfunction

endpackage

// File: rtl/weight_rd_valid_pipe.sv
// Delays the DRM read strobe by the memory read latency so it qualifies read data.
module weight_rd_valid_pipe #(
   parameter int LATENCY = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [LATENCY-1:0] sr_q;

   generate
      if (LATENCY == 1) begin : g_single
         // single-stage delay
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) sr_q <= '0;
            else        sr_q <= d;
         end
      end else begin : g_multi
         // multi-stage shift, oldest strobe at the top bit
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) sr_q <= '0;
            else        sr_q <= {sr_q[LATENCY-2:0], d};
         end
      end
   endgenerate

   assign q = sr_q[LATENCY-1];

endmodule

// File: rtl/weight_mem_sched.sv
// Weight memory sequencer: writes converted DDR words into the DRM bank and
// streams completed rows to the MAC array over one or more passes.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  IDLE    | waiting for a valid start; config not latched
//  FILL    | loading words, fewer than one full row written so far
//  RUN     | loading continues, rows issued as soon as they are complete
//  DONE    | one-cycle completion, state_rst pulses, back to IDLE
module weight_mem_sched
   import weight_mem_pkg::*;
#(
   parameter int WR_ADDR_DEPTH = 10,
   parameter int RD_ADDR_DEPTH = 8,
   parameter int PASS_WIDTH    = 8,
   parameter int RD_LATENCY    = 1
) (
   input  logic                     sys_clk,
   input  logic                     rstn,
   input  logic                     start,
   input  logic [WR_ADDR_DEPTH:0]   cfg_words,
   input  logic [PASS_WIDTH-1:0]    cfg_passes,
   input  logic                     abort,
   input  logic                     wr_valid_in,
   input  logic                     rd_ready,
   output logic                     wr_en,
   output logic [WR_ADDR_DEPTH-1:0] addr_wr,
   output logic                     rd_en,
   output logic [RD_ADDR_DEPTH-1:0] addr_rd,
   output logic                     rd_valid_out,
   output logic                     busy,
   output logic                     load_done,
   output logic                     state_rst,
   output logic                     err_cfg,
   output logic                     err_overflow
);

   generate
      if (!rd_depth_ok(WR_ADDR_DEPTH, RD_ADDR_DEPTH)) begin : g_depth_chk
         $error("RD_ADDR_DEPTH must equal WR_ADDR_DEPTH-2");
      end
   endgenerate

   localparam int CW = WR_ADDR_DEPTH + 1;
   localparam logic [CW-1:0] MAX_WORDS = {1'b1, {WR_ADDR_DEPTH{1'b0}}};

   state_t                  state_q, state_d;
   logic [CW-1:0]           wr_cnt_q, cfg_words_q, wr_cnt_nxt;
   logic [RD_ADDR_DEPTH-1:0] row_q;
   logic [RD_ADDR_DEPTH:0]  row_p1;
   logic [PASS_WIDTH-1:0]   pass_q, cfg_passes_q;
   logic                    load_done_q, err_ovf_q, err_cfg_q;
   logic                    cfg_ok, start_ok, start_bad, writing;
   logic                    row_last, pass_last, sweep_done;

   assign cfg_ok    = (cfg_words != '0) && (cfg_words[1:0] == 2'b00) && (cfg_words <= MAX_WORDS);
   assign start_ok  = start && (state_q == ST_IDLE) && cfg_ok && !abort;
   assign start_bad = start && (state_q == ST_IDLE) && !cfg_ok && !abort;
   assign writing   = (state_q == ST_FILL) || (state_q == ST_RUN);

   assign wr_en      = writing && wr_valid_in && (wr_cnt_q < cfg_words_q);
   assign wr_cnt_nxt = wr_en ? wr_cnt_q + CW'(1) : wr_cnt_q;
   assign addr_wr    = wr_cnt_q[WR_ADDR_DEPTH-1:0];

   // A row is readable once all of its words are in; the row count of
   // written words is wr_cnt>>2, which is one bit wider than a row address.
   assign row_p1     = {1'b0, row_q} + {{RD_ADDR_DEPTH{1'b0}}, 1'b1};
   assign rd_en      = (state_q == ST_RUN) && rd_ready && (row_p1 <= wr_cnt_q[CW-1:2]);
   assign addr_rd    = row_q;
   assign row_last   = (row_p1 == cfg_words_q[CW-1:2]);
   assign pass_last  = (pass_q == cfg_passes_q - PASS_WIDTH'(1));
   assign sweep_done = rd_en && row_last && pass_last;

   assign busy         = (state_q != ST_IDLE);
   assign state_rst    = (state_q == ST_DONE);
   assign load_done    = load_done_q;
   assign err_cfg      = err_cfg_q;
   assign err_overflow = err_ovf_q;

   // state register
   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // next-state; abort wins over start and completion
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: if (start_ok) state_d = ST_FILL;
            ST_FILL: if (wr_cnt_nxt >= CW'(WORDS_PER_ROW)) state_d = ST_RUN;
            ST_RUN:  if (sweep_done) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // config latch, write/read counters and sticky flags
   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         cfg_words_q  <= '0;
         cfg_passes_q <= '0;
         wr_cnt_q     <= '0;
         row_q        <= '0;
         pass_q       <= '0;
         load_done_q  <= 1'b0;
         err_ovf_q    <= 1'b0;
         err_cfg_q    <= 1'b0;
      end else if (abort) begin
         wr_cnt_q    <= '0;
         row_q       <= '0;
         pass_q      <= '0;
         load_done_q <= 1'b0;
         err_ovf_q   <= 1'b0;
         err_cfg_q   <= 1'b0;
      end else begin
         err_cfg_q <= start_bad;
         if (start_ok) begin
            cfg_words_q  <= cfg_words;
            cfg_passes_q <= (cfg_passes == '0) ? PASS_WIDTH'(1) : cfg_passes;
            wr_cnt_q     <= '0;
            row_q        <= '0;
            pass_q       <= '0;
            load_done_q  <= 1'b0;
            err_ovf_q    <= 1'b0;
         end else begin
            if (wr_en) begin
               wr_cnt_q <= wr_cnt_nxt;
               if (wr_cnt_nxt == cfg_words_q) load_done_q <= 1'b1;
            end
            // any valid word that could not be written is an overflow
            if (wr_valid_in && !wr_en) err_ovf_q <= 1'b1;
            if (rd_en) begin
               if (row_last) begin
                  row_q  <= '0;
                  pass_q <= pass_q + PASS_WIDTH'(1);
               end else begin
                  row_q <= row_p1[RD_ADDR_DEPTH-1:0];
               end
            end
         end
      end
   end

   weight_rd_valid_pipe #(
      .LATENCY (RD_LATENCY)
   ) u_rd_valid_pipe (
      .clk   (sys_clk),
      .rst_n (rstn),
      .d     (rd_en),
      .q     (rd_valid_out)
   );

endmodule

// File: doc/weight_mem_sched.md
Name: weight_mem_sched

Overview:
- Sequencer for the weight memory: issues write addresses and enables for 324-bit converted DDR words into the weight DRM bank.
- Issues 1296-bit read rows toward the MAC array, one row = 4 write words.
- Reading overlaps loading: row r is issued only once all 4 of its words are written.
- Supports multiple read passes over the loaded set, then pulses state_rst to hand control back to the top-level layer FSM.

Parameters:
- WR_ADDR_DEPTH, 10, write address width (324-bit words)
- RD_ADDR_DEPTH, 8, read address width (1296-bit rows); must equal WR_ADDR_DEPTH-2
- PASS_WIDTH, 8, width of read-pass count
- RD_LATENCY, 1, DRM read latency in cycles, used to align rd_valid_out

Ports:
- sys_clk  in  1  single clock for write and sequencing
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches cfg_* when IDLE
- cfg_words  in  WR_ADDR_DEPTH+1  number of 324-bit words to load
- cfg_passes  in  PASS_WIDTH  number of full read sweeps (0 treated as 1)
- abort  in  1  synchronous return to IDLE
- wr_valid_in  in  1  converted DDR word valid this cycle
- rd_ready  in  1  downstream accepts a read row this cycle
- wr_en  out  1  DRM write enable
- addr_wr  out  WR_ADDR_DEPTH  DRM write address
- rd_en  out  1  DRM read enable
- addr_rd  out  RD_ADDR_DEPTH  DRM read address
- rd_valid_out  out  1  rd_en delayed RD_LATENCY cycles; qualifies DRM read data
- busy  out  1  high in any state except IDLE
- load_done  out  1  sticky high once cfg_words written; cleared on next start or abort
- state_rst  out  1  one-cycle pulse at completion
- err_cfg  out  1  one-cycle pulse on rejected start
- err_overflow  out  1  sticky; cleared on start or abort

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; rd_valid pipeline cleared.
- States:
  - IDLE -> FILL on valid start.
  - FILL -> RUN when wr_cnt >= 4.
  - RUN -> DONE after the last row of the last pass is issued.
  - DONE -> IDLE unconditionally after 1 cycle.
- Start validity: cfg_words != 0, cfg_words[1:0]==0, and cfg_words <= 2^WR_ADDR_DEPTH.
  - Otherwise err_cfg pulses 1 cycle; stay IDLE; no cfg latched.
  - Start while busy is ignored, no error.
- Writes (FILL and RUN): wr_en = wr_valid_in && wr_cnt < cfg_words, combinational; addr_wr = wr_cnt[WR_ADDR_DEPTH-1:0].
  - wr_cnt increments on wr_en.
  - When wr_cnt reaches cfg_words, load_done is set next cycle.
  - wr_valid_in with wr_cnt == cfg_words, or wr_valid_in in IDLE/DONE: no write; err_overflow set.
- Reads (RUN only): rd_en = rd_ready && (4*(row+1) <= wr_cnt), combinational; addr_rd = row.
  - On rd_en, row increments.
  - At row == cfg_words/4 - 1 with rd_en: row wraps to 0 and pass increments.
  - After the final row of pass cfg_passes-1 -> DONE.
  - Passes after the first never stall on wr_cnt, since the load is complete.
- Write and read in the same cycle are independent and both legal; a row completed this cycle is readable next cycle.
- rd_valid_out: shift register of rd_en, RD_LATENCY deep; still drains after DONE/abort, so in-flight data stays qualified.
- DONE: state_rst=1 for exactly 1 cycle; busy=1 in DONE.
- abort: any state -> IDLE next cycle.
  - Counters, load_done and err_overflow cleared.
  - No state_rst pulse.
  - Abort has priority over start and completion in the same cycle.
- Async reset mid-operation: immediate return to reset values; no pulse.
- Arithmetic: wr_cnt is WR_ADDR_DEPTH+1 bits so the full 2^WR_ADDR_DEPTH load is representable; row compare uses wr_cnt>>2.

Decomposition:
- Shared package weight_mem_pkg holds:
  - state encoding: IDLE=0, FILL=1, RUN=2, DONE=3 (2-bit)
  - WORDS_PER_ROW=4 constant
  - the RD_ADDR_DEPTH = WR_ADDR_DEPTH-2 relation check
- One sub-module: weight_rd_valid_pipe, the RD_LATENCY-deep valid shift register with async clear.
- Write/read counters stay in the top FSM file.

Test Plan:
- Basic load/read: start, cfg_words=8, cfg_passes=1; 8 consecutive wr_valid_in, rd_ready=1 -> addr_wr 0..7; rd_en first asserts the cycle after the 4th write with addr_rd=0, then addr_rd=1; state_rst pulses once; busy low after.
- Overlap stall: cfg_words=16, wr_valid_in every 3rd cycle, rd_ready=1 -> rd_en for row r never before the cycle after write 4r+3; rows 0..3 read in order.
- Multi-pass with backpressure: cfg_words=8, cfg_passes=3, rd_ready toggling 1/0 -> addr_rd sequence 0,1,0,1,0,1; rd_valid_out equals rd_en delayed 1 cycle; exactly one state_rst.
- Config errors: start with cfg_words=6, then cfg_words=0 -> err_cfg pulse each time, busy stays 0; cfg_words=1024 accepted and wr_cnt reaches 1024 without wrap.
- Overflow: cfg_words=4, 6 wr_valid_in pulses -> exactly 4 wr_en, err_overflow=1 sticky until next start.
- Abort/reset: abort in RUN at row 2 of cfg_words=16 -> IDLE next cycle, no state_rst, load_done=0; assert rstn=0 mid-FILL -> all outputs 0 immediately.
